seq_divider: RTL and testbench

- Multi-cycle restoring integer divider; downstream consumer of the add/sub unit.
- Each iteration issues one trial subtraction through an internal addsub instance (width n+1, sub=1, cin=0); its sum/cout decide restore vs. keep.
- Produces one quotient bit per cycle, with a start/busy/done handshake toward the datapath controller.

---
 rtl/seq_divider.sv | 149 ++++++++++++++
 tb/tb_seq_divider.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider, one quotient bit per cycle via an addsub trial stage
// Optional two's-complement mode: define SEQ_DIVIDER_SIGNED_EN to add the signed_op input.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

module addsub #(
   parameter int w = 9
) (
   input  logic [w-1:0] i_a,
   input  logic [w-1:0] i_b,
   input  logic         i_sub,
   input  logic         i_cin,
   output logic [w-1:0] o_sum,
   output logic         o_cout
);
   logic [w:0] w_res;

   // In subtract mode the carry-out is the borrow of a - b - cin.
   always_comb begin
      if (i_sub) w_res = {1'b0, i_a} - {1'b0, i_b} - {{w{1'b0}}, i_cin};
      else       w_res = {1'b0, i_a} + {1'b0, i_b} + {{w{1'b0}}, i_cin};
   end

   assign o_sum  = w_res[w-1:0];
   assign o_cout = w_res[w];
endmodule

module seq_divider #(
   parameter int n = `DEFAULT_WIDTH
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
`ifdef SEQ_DIVIDER_SIGNED_EN
   input  logic         signed_op,
`endif
   input  logic [n-1:0] dividend,
   input  logic [n-1:0] divisor,
   output logic [n-1:0] quotient,
   output logic [n-1:0] remainder,
   output logic         busy,
   output logic         done,
   output logic         div_by_zero
);
   localparam int CW = $clog2(n);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t         r_state, w_next;
   logic [n-1:0]   r_rem, r_q, r_dvs;
   logic [CW-1:0]  r_cnt;
   logic           r_dz, r_neg_q, r_neg_r;

   logic [n:0]     w_t, w_sum;
   logic           w_cout, w_borrow, w_accept;
   logic [n-1:0]   w_rem_nxt, w_q_nxt, w_mag_dvd, w_mag_dvs;
   logic           w_neg_q, w_neg_r;

`ifdef SEQ_DIVIDER_SIGNED_EN
   assign w_mag_dvd = (signed_op && dividend[n-1]) ? -dividend : dividend;
   assign w_mag_dvs = (signed_op && divisor[n-1])  ? -divisor  : divisor;
   assign w_neg_q   = signed_op && (dividend[n-1] ^ divisor[n-1]);
   assign w_neg_r   = signed_op && dividend[n-1];
`else
   assign w_mag_dvd = dividend;
   assign w_mag_dvs = divisor;
   assign w_neg_q   = 1'b0;
   assign w_neg_r   = 1'b0;
`endif

   assign w_t = {r_rem, r_q[n-1]};

   addsub #(.w(n + 1)) u_addsub (
      .i_a    (w_t),
      .i_b    ({1'b0, r_dvs}),
      .i_sub  (1'b1),
      .i_cin  (1'b0),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // A kept difference is always below the divisor, so sum[n] can only be set alongside a borrow.
   assign w_borrow  = w_cout | w_sum[n];
   assign w_rem_nxt = w_borrow ? w_t[n-1:0] : w_sum[n-1:0];
   assign w_q_nxt   = {r_q[n-2:0], ~w_borrow};
   assign w_accept  = start && (r_state != S_RUN);

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         S_IDLE: if (start) w_next = S_RUN;
         S_RUN: begin
            busy = 1'b1;
            if (r_dz || r_cnt == '0) w_next = S_DONE;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = start ? S_RUN : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_rem       <= '0;
         r_q         <= '0;
         r_dvs       <= '0;
         r_cnt       <= '0;
         r_dz        <= 1'b0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            // On divide-by-zero r_q keeps the raw dividend for the remainder output.
            r_q         <= (divisor == '0) ? dividend : w_mag_dvd;
            r_dvs       <= w_mag_dvs;
            r_rem       <= '0;
            r_cnt       <= CW'(n - 1);
            r_dz        <= (divisor == '0);
            r_neg_q     <= w_neg_q;
            r_neg_r     <= w_neg_r;
            div_by_zero <= 1'b0;
         end else if (r_state == S_RUN) begin
            if (r_dz) begin
               quotient    <= '1;
               remainder   <= r_q;
               div_by_zero <= 1'b1;
            end else begin
               r_rem <= w_rem_nxt;
               r_q   <= w_q_nxt;
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == '0) begin
                  quotient  <= r_neg_q ? -w_q_nxt : w_q_nxt;
                  remainder <= r_neg_r ? -w_rem_nxt : w_rem_nxt;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider (n=8)
`timescale 1ns/1ps
module tb_seq_divider;
   logic       clk = 1'b0;
   logic       reset, start;
   logic [7:0] dividend, divisor, quotient, remainder;
   logic       busy, done, div_by_zero;
`ifdef SEQ_DIVIDER_SIGNED_EN
   logic       signed_op = 1'b0;
`endif
   int n_cmp = 0;
   int n_fail = 0;

   seq_divider #(.n(8)) dut (
      .clk(clk), .reset(reset), .start(start),
`ifdef SEQ_DIVIDER_SIGNED_EN
      .signed_op(signed_op),
`endif
      .dividend(dividend), .divisor(divisor), .quotient(quotient), .remainder(remainder),
      .busy(busy), .done(done), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic issue(input logic [7:0] a, input logic [7:0] b);
      dividend = a; divisor = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (done !== 1'b1 && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      n_cmp++; if (quotient !== 8'd0) begin n_fail++; $display("FAIL reset_q got %0d want 0", quotient); end
      n_cmp++; if (remainder !== 8'd0) begin n_fail++; $display("FAIL reset_r got %0d want 0", remainder); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz got %b want 0", div_by_zero); end
   endtask

   task automatic test_basic();
      int lat;
      issue(8'd100, 8'd7);
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
      wait_done(lat);
      n_cmp++; if (lat != 8) begin n_fail++; $display("FAIL basic_latency got %0d want 8", lat); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
      n_cmp++; if (quotient !== 8'd14) begin n_fail++; $display("FAIL basic_q got %0d want 14", quotient); end
      n_cmp++; if (remainder !== 8'd2) begin n_fail++; $display("FAIL basic_r got %0d want 2", remainder); end
      n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dz got %b want 0", div_by_zero); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", done); end
      n_cmp++; if (quotient !== 8'd14) begin n_fail++; $display("FAIL basic_q_held got %0d want 14", quotient); end
      issue(8'd255, 8'd1);
      wait_done(lat);
      n_cmp++; if (quotient !== 8'd255) begin n_fail++; $display("FAIL max_q got %0d want 255", quotient); end
      n_cmp++; if (remainder !== 8'd0) begin n_fail++; $display("FAIL max_r got %0d want 0", remainder); end
      @(posedge clk); #1;
      issue(8'd5, 8'd9);
      wait_done(lat);
      n_cmp++; if (quotient !== 8'd0) begin n_fail++; $display("FAIL small_q got %0d want 0", quotient); end
      n_cmp++; if (remainder !== 8'd5) begin n_fail++; $display("FAIL small_r got %0d want 5", remainder); end
      @(posedge clk); #1;
   endtask

   task automatic test_div_by_zero();
      int lat;
      issue(8'd37, 8'd0);
      wait_done(lat);
      n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL dz_latency got %0d want 1", lat); end
      n_cmp++; if (quotient !== 8'hFF) begin n_fail++; $display("FAIL dz_q got %0d want 255", quotient); end
      n_cmp++; if (remainder !== 8'd37) begin n_fail++; $display("FAIL dz_r got %0d want 37", remainder); end
      n_cmp++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
      @(posedge clk); #1;
      n_cmp++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag_held got %b want 1", div_by_zero); end
      issue(8'd10, 8'd3);
      n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dz_clear got %b want 0", div_by_zero); end
      wait_done(lat);
      n_cmp++; if (quotient !== 8'd3) begin n_fail++; $display("FAIL after_dz_q got %0d want 3", quotient); end
      n_cmp++; if (remainder !== 8'd1) begin n_fail++; $display("FAIL after_dz_r got %0d want 1", remainder); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int lat;
      issue(8'd100, 8'd7);
      repeat (2) begin @(posedge clk); #1; end
      issue(8'd50, 8'd5);
      wait_done(lat);
      n_cmp++; if (lat + 3 != 8) begin n_fail++; $display("FAIL ignored_latency got %0d want 8", lat + 3); end
      n_cmp++; if (quotient !== 8'd14) begin n_fail++; $display("FAIL ignored_q got %0d want 14", quotient); end
      n_cmp++; if (remainder !== 8'd2) begin n_fail++; $display("FAIL ignored_r got %0d want 2", remainder); end
      issue(8'd9, 8'd4);
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop got %b want 0", done); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b want 1", busy); end
      wait_done(lat);
      n_cmp++; if (lat != 8) begin n_fail++; $display("FAIL b2b_latency got %0d want 8", lat); end
      n_cmp++; if (quotient !== 8'd2) begin n_fail++; $display("FAIL b2b_q got %0d want 2", quotient); end
      n_cmp++; if (remainder !== 8'd1) begin n_fail++; $display("FAIL b2b_r got %0d want 1", remainder); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_run();
      int seen;
      issue(8'd200, 8'd3);
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b1; #1;
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
      n_cmp++; if (quotient !== 8'd0) begin n_fail++; $display("FAIL abort_q got %0d want 0", quotient); end
      n_cmp++; if (remainder !== 8'd0) begin n_fail++; $display("FAIL abort_r got %0d want 0", remainder); end
      @(posedge clk); #1;
      reset = 1'b0;
      seen = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen++;
      end
      n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
   endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
   task automatic test_signed();
      int lat;
      signed_op = 1'b1;
      issue(8'hF9, 8'd2);
      wait_done(lat);
      n_cmp++; if (quotient !== 8'hFD) begin n_fail++; $display("FAIL s1_q got %h want fd", quotient); end
      n_cmp++; if (remainder !== 8'hFF) begin n_fail++; $display("FAIL s1_r got %h want ff", remainder); end
      issue(8'd7, 8'hFE);
      wait_done(lat);
      n_cmp++; if (quotient !== 8'hFD) begin n_fail++; $display("FAIL s2_q got %h want fd", quotient); end
      n_cmp++; if (remainder !== 8'h01) begin n_fail++; $display("FAIL s2_r got %h want 01", remainder); end
      issue(8'h80, 8'hFF);
      wait_done(lat);
      n_cmp++; if (lat != 8) begin n_fail++; $display("FAIL s3_latency got %0d want 8", lat); end
      n_cmp++; if (quotient !== 8'h80) begin n_fail++; $display("FAIL s3_q got %h want 80", quotient); end
      n_cmp++; if (remainder !== 8'h00) begin n_fail++; $display("FAIL s3_r got %h want 00", remainder); end
      n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL s3_dz got %b want 0", div_by_zero); end
      @(posedge clk); #1;
      signed_op = 1'b0;
   endtask
`endif

   initial begin
      reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      reset = 1'b0;
      @(posedge clk); #1;
      test_basic();
      test_div_by_zero();
      test_back_to_back();
`ifdef SEQ_DIVIDER_SIGNED_EN
      test_signed();
`endif
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
